// File: rtl/sw_debounce.sv
// Switch conditioner: two-flop synchronizer, then a per-channel hold-time filter with registered strobes.
// Latency DB_CYCLES+2 edges from pad to sw_level; no backpressure (level outputs plus 1-cycle strobes).
module sw_debounce #(
  parameter int WIDTH     = 3,
  parameter int DB_CYCLES = 240000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_any
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  state_e           state [WIDTH];

  // The state register is implicit: a channel is pending whenever s2 disagrees with the accepted level.
  always_comb begin
    s1_d    = sw;
    s2_d    = s1_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      state[i] = (s2_q[i] == level_q[i]) ? ST_STABLE : ST_PENDING;
      case (state[i])
        ST_STABLE: cnt_d[i] = '0;
        ST_PENDING: begin
          if (cnt_q[i] == CNT_MAX) begin
            level_d[i] = s2_q[i];
            rise_d[i]  = s2_q[i];
            fall_d[i]  = ~s2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_level = level_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;
  assign sw_any   = |{rise_q, fall_q};

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (WIDTH=3, DB_CYCLES=8): expected strobe events are queued with their due cycle.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sw;
  logic [2:0] sw_level, sw_rise, sw_fall;
  logic       sw_any;

  sw_debounce #(.WIDTH(3), .DB_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .sw_any   (sw_any)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      tag;
    int         at;
    logic [2:0] lvl;
    logic [2:0] rise;
    logic [2:0] fall;
    logic       any;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] exp_level = 3'b000;
  int         total  = 0;
  int         passed = 0;
  int         t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b required %b", tag, obs, exp);
  endtask

  task automatic push(input string tag, input int at, input logic [2:0] lvl,
                      input logic [2:0] rise, input logic [2:0] fall, input logic any);
    exp_t e;
    e.tag = tag; e.at = at; e.lvl = lvl; e.rise = rise; e.fall = fall; e.any = any;
    sb.push_back(e);
  endtask

  // One clock; outputs compared 1 time unit after the edge against a due event or the quiet state.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      chk(e.tag, {22'd0, sw_level, sw_rise, sw_fall, sw_any}, {22'd0, e.lvl, e.rise, e.fall, e.any});
      exp_level = e.lvl;
    end else begin
      chk("idle", {22'd0, sw_level, sw_rise, sw_fall, sw_any}, {22'd0, exp_level, 7'b0});
    end
  endtask

  initial begin
    // Reset and power-up: switches already at 101 are reported as a rise.
    rst_n = 1'b1;
    sw    = 3'b101;
    #1 rst_n = 1'b0;
    #1 chk("rst_async", {sw_level, sw_rise, sw_fall, sw_any}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    t0 = cyc;
    push("pwr_rise", t0 + 10, 3'b101, 3'b101, 3'b000, 1'b1);
    repeat (14) tick();

    // Clean step on channel 1.
    sw = 3'b111;
    push("step_rise", cyc + 10, 3'b111, 3'b010, 3'b000, 1'b1);
    repeat (14) tick();

    // All channels fall together.
    sw = 3'b000;
    push("all_fall", cyc + 10, 3'b000, 3'b000, 3'b111, 1'b1);
    repeat (14) tick();

    // Seven-cycle glitch on channel 0 is rejected.
    sw = 3'b001;
    repeat (7) tick();
    sw = 3'b000;
    repeat (12) tick();

    // Eight-cycle pulse is just long enough; the drop is then accepted as a fall.
    sw = 3'b001;
    t0 = cyc;
    push("edge8_rise", t0 + 10, 3'b001, 3'b001, 3'b000, 1'b1);
    push("edge8_fall", t0 + 18, 3'b000, 3'b000, 3'b001, 1'b1);
    repeat (8) tick();
    sw = 3'b000;
    repeat (14) tick();

    // Bounce on channel 2: acceptance counted from the last toggle.
    sw = 3'b100; repeat (3) tick();
    sw = 3'b000; repeat (3) tick();
    sw = 3'b100; repeat (3) tick();
    sw = 3'b000; repeat (3) tick();
    sw = 3'b100;
    push("bounce_rise", cyc + 10, 3'b100, 3'b100, 3'b000, 1'b1);
    repeat (14) tick();

    // Reset in the middle of a count on channel 1.
    sw = 3'b110;
    repeat (7) tick();
    rst_n = 1'b0;
    #1 chk("rst_mid", {sw_level, sw_rise, sw_fall, sw_any}, 0);
    exp_level = 3'b000;
    sw = 3'b010;
    repeat (2) tick();
    rst_n = 1'b1;
    push("post_rst_rise", cyc + 10, 3'b010, 3'b010, 3'b000, 1'b1);
    repeat (14) tick();

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
